tx_rr_lock_arbiter: RTL

- Work-conserving round-robin arbiter that decides which of N per-subAFU TX queues is dequeued each cycle onto one shared CCI-P TX channel.
- Generates a one-hot read-ack and the winning index for the downstream mux stage.
- Honours downstream almost-full back-pressure.
- Locks onto one requester for the full duration of a multi-line packet, so packet beats are never interleaved.
- One instance is used per TX channel (c0, c1, c2).

---
 rtl/tx_rr_lock_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/tx_rr_lock_arbiter.sv
// Round-robin TX queue arbiter with packet lock, almost-full back-pressure and optional per-grant gap.
// Define TX_RR_LOCK_ARBITER_STATS_EN to add per-requester grant counters (stat_sel/stat_clr/stat_count).
module tx_rr_lock_arbiter #(
  parameter int N_REQ     = 16,
  parameter int GRANT_GAP = 0,
  localparam int IDX_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  input  logic             out_almFull,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
`ifdef TX_RR_LOCK_ARBITER_STATS_EN
  input  logic [IDX_W-1:0] stat_sel,
  input  logic             stat_clr,
  output logic [31:0]      stat_count,
`endif
  output logic             locked
);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [N_REQ-1:0] elig;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;
  logic             do_grant;
  logic [IDX_W-1:0] sel_idx;

  // Gap counters mask a requester for GRANT_GAP cycles after each of its grants.
  if (GRANT_GAP > 0) begin : g_gap
    localparam int GAP_W = $clog2(GRANT_GAP + 1);
    logic [GAP_W-1:0] gap_cnt [N_REQ];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < N_REQ; i++) gap_cnt[i] <= '0;
      end else begin
        for (int i = 0; i < N_REQ; i++) begin
          if (do_grant && sel_idx == IDX_W'(i))
            gap_cnt[i] <= GAP_W'(GRANT_GAP);
          else if (gap_cnt[i] != '0)
            gap_cnt[i] <= gap_cnt[i] - 1'b1;
        end
      end
    end

    always_comb begin
      elig = '0;
      for (int i = 0; i < N_REQ; i++) elig[i] = req[i] & (gap_cnt[i] == '0);
    end
  end else begin : g_no_gap
    assign elig = req;
  end

  // Circular search for the first eligible requester starting at ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!win_found && elig[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_ARB;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    do_grant  = 1'b0;
    sel_idx   = win_idx;
    case (state)
      ST_ARB: begin
        if (!out_almFull && win_found) begin
          do_grant = 1'b1;
          sel_idx  = win_idx;
          ptr_nxt  = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          if (lock[win_idx]) begin
            owner_nxt = win_idx;
            state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        // The pointer already sits past the owner; only the owner may advance.
        sel_idx = owner;
        if (!out_almFull && elig[owner]) begin
          do_grant = 1'b1;
          if (!lock[owner]) state_nxt = ST_ARB;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  // Registered grant outputs, one cycle after sampling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      grant       <= do_grant ? (N_REQ'(1) << sel_idx) : '0;
      grant_valid <= do_grant;
      if (do_grant) grant_idx <= sel_idx;
    end
  end

  assign locked = (state == ST_LOCKED);

`ifdef TX_RR_LOCK_ARBITER_STATS_EN
  logic [31:0] stat_cnt [N_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) stat_cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (stat_clr)
          stat_cnt[i] <= '0;
        else if (do_grant && sel_idx == IDX_W'(i) && stat_cnt[i] != 32'hFFFF_FFFF)
          stat_cnt[i] <= stat_cnt[i] + 32'd1;
      end
      stat_count <= stat_cnt[stat_sel];
    end
  end
`endif

endmodule
